// File: rtl/johnson_counter_gen.sv
// Parametrised Johnson (twisted-ring) counter with enable, direction, parallel load,
// phase index, wrap pulse and illegal-state detection with optional self-correction.
module johnson_counter_gen #(
   parameter int               WIDTH        = 6,
   parameter logic [WIDTH-1:0] RESET_VAL    = '0,
   parameter bit               SELF_CORRECT = 1'b1,
   localparam int              PW           = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [PW-1:0]    phase,
   output logic             wrap,
   output logic             illegal
);

   // A Johnson state has at most one boundary between adjacent differing bits.
   function automatic logic is_legal(input logic [WIDTH-1:0] v);
      int edges;
      edges = 0;
      for (int i = 0; i < WIDTH-1; i++) begin
         if (v[i] != v[i+1]) edges = edges + 1;
      end
      return (edges <= 1);
   endfunction

   // Low-filled patterns sit in the first half of the cycle, high-filled in the second.
   function automatic logic [PW-1:0] index_of(input logic [WIDTH-1:0] v);
      int k;
      k = $countones(v);
      if (v[0] || (k == 0)) return PW'(k);
      else                  return PW'(2*WIDTH - k);
   endfunction

   localparam logic [PW-1:0] LAST_PHASE  = PW'(2*WIDTH - 1);
   localparam logic [PW-1:0] RESET_PHASE = index_of(RESET_VAL);

   logic [WIDTH-1:0] q_reg, q_next;
   logic [PW-1:0]    phase_reg, phase_next;
   logic             wrap_reg, wrap_next;
   logic [WIDTH-1:0] up_q, dn_q;
   logic             illegal_now;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_up_lsb
         assign up_q[gi] = ~q_reg[WIDTH-1];
      end else begin : g_up_mid
         assign up_q[gi] = q_reg[gi-1];
      end
      if (gi == WIDTH-1) begin : g_dn_msb
         assign dn_q[gi] = ~q_reg[0];
      end else begin : g_dn_mid
         assign dn_q[gi] = q_reg[gi+1];
      end
   end

   assign illegal_now = ~is_legal(q_reg);

   always_comb begin
      q_next     = q_reg;
      phase_next = phase_reg;
      wrap_next  = 1'b0;
      if (load) begin
         q_next     = load_val;
         phase_next = is_legal(load_val) ? index_of(load_val) : '0;
      end else if (illegal_now && SELF_CORRECT) begin
         q_next     = '0;
         phase_next = '0;
      end else if (en) begin
         q_next = dir ? dn_q : up_q;
         // An illegal state keeps shifting but its phase is meaningless, so it holds.
         if (!illegal_now) begin
            if (!dir) begin
               phase_next = (phase_reg == LAST_PHASE) ? '0 : phase_reg + 1'b1;
               wrap_next  = (phase_reg == LAST_PHASE);
            end else begin
               phase_next = (phase_reg == '0) ? LAST_PHASE : phase_reg - 1'b1;
               wrap_next  = (phase_reg == '0);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg     <= RESET_VAL;
         phase_reg <= RESET_PHASE;
         wrap_reg  <= 1'b0;
      end else begin
         q_reg     <= q_next;
         phase_reg <= phase_next;
         wrap_reg  <= wrap_next;
      end
   end

   assign q       = q_reg;
   assign phase   = phase_reg;
   assign wrap    = wrap_reg;
   assign illegal = illegal_now;

endmodule

// File: tb/tb_johnson_counter_gen.sv
// Directed bench for johnson_counter_gen: 6-bit self-correcting, 6-bit detect-only
// and 2-bit builds share one stimulus stream.
module tb_johnson_counter_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       dir = 1'b0;
   logic       load = 1'b0;
   logic [5:0] load_val = '0;
   logic [1:0] load_val2 = 2'b00;

   logic [5:0] q6, qn;
   logic [3:0] ph6, phn;
   logic       wr6, wrn, il6, iln;
   logic [1:0] q2, ph2;
   logic       wr2, il2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   johnson_counter_gen #(.WIDTH(6), .RESET_VAL(6'b0), .SELF_CORRECT(1'b1)) dut (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
      .q(q6), .phase(ph6), .wrap(wr6), .illegal(il6));

   johnson_counter_gen #(.WIDTH(6), .RESET_VAL(6'b0), .SELF_CORRECT(1'b0)) dut_nc (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
      .q(qn), .phase(phn), .wrap(wrn), .illegal(iln));

   johnson_counter_gen #(.WIDTH(2), .RESET_VAL(2'b0), .SELF_CORRECT(1'b1)) dut_w2 (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val2),
      .q(q2), .phase(ph2), .wrap(wr2), .illegal(il2));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [5:0] up_tab [12] = '{6'b000001, 6'b000011, 6'b000111, 6'b001111, 6'b011111, 6'b111111,
                               6'b111110, 6'b111100, 6'b111000, 6'b110000, 6'b100000, 6'b000000};
   logic [5:0] dn_tab [12] = '{6'b100000, 6'b110000, 6'b111000, 6'b111100, 6'b111110, 6'b111111,
                               6'b011111, 6'b001111, 6'b000111, 6'b000011, 6'b000001, 6'b000000};
   logic [1:0] w2_tab [4]  = '{2'b01, 2'b11, 2'b10, 2'b00};

   initial begin
      // 1: reset, then count up one full period
      rst = 1'b1;
      step();
      step();
      check_eq("rst_q", 32'(q6), 0);
      check_eq("rst_phase", 32'(ph6), 0);
      check_eq("rst_wrap", 32'(wr6), 0);
      check_eq("rst_illegal", 32'(il6), 0);
      check_eq("rst_w2_q", 32'(q2), 0);
      rst = 1'b0; en = 1'b1; dir = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         check_eq($sformatf("up_q[%0d]", i), 32'(q6), 32'(up_tab[i]));
         check_eq($sformatf("up_phase[%0d]", i), 32'(ph6), 32'((i + 1) % 12));
         check_eq($sformatf("up_wrap[%0d]", i), 32'(wr6), 32'(i == 11));
         check_eq($sformatf("w2_q[%0d]", i), 32'(q2), 32'(w2_tab[i % 4]));
         check_eq($sformatf("w2_phase[%0d]", i), 32'(ph2), 32'((i + 1) % 4));
         check_eq($sformatf("w2_wrap[%0d]", i), 32'(wr2), 32'((i % 4) == 3));
      end

      // 2: count down from 000000
      dir = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         check_eq($sformatf("dn_q[%0d]", i), 32'(q6), 32'(dn_tab[i]));
         check_eq($sformatf("dn_phase[%0d]", i), 32'(ph6), 32'(11 - i));
         check_eq($sformatf("dn_wrap[%0d]", i), 32'(wr6), 32'(i == 0));
      end

      // 3: hold at 000111, then toggle direction each cycle
      dir = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check_eq("pre_hold_q", 32'(q6), 32'h07);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq($sformatf("hold_q[%0d]", i), 32'(q6), 32'h07);
         check_eq($sformatf("hold_phase[%0d]", i), 32'(ph6), 3);
         check_eq($sformatf("hold_wrap[%0d]", i), 32'(wr6), 0);
      end
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dir = i[0];
         step();
         check_eq($sformatf("toggle_q[%0d]", i), 32'(q6), (i % 2 == 0) ? 32'h0F : 32'h07);
      end

      // 4: parallel load, step after load, load beats en
      load = 1'b1; load_val = 6'b111000; en = 1'b0; dir = 1'b0;
      step();
      check_eq("load_q", 32'(q6), 32'h38);
      check_eq("load_phase", 32'(ph6), 9);
      check_eq("load_illegal", 32'(il6), 0);
      load = 1'b0; en = 1'b1;
      step();
      check_eq("post_load_q", 32'(q6), 32'h30);
      check_eq("post_load_phase", 32'(ph6), 10);
      load = 1'b1; load_val = 6'b000011;
      step();
      check_eq("load_vs_en_q", 32'(q6), 32'h03);
      check_eq("load_vs_en_phase", 32'(ph6), 2);

      // 5: illegal value, self-correct vs detect-only
      load_val = 6'b010101; en = 1'b0;
      step();
      check_eq("ill_q", 32'(q6), 32'h15);
      check_eq("ill_flag", 32'(il6), 1);
      check_eq("ill_nc_flag", 32'(iln), 1);
      check_eq("ill_nc_phase", 32'(phn), 0);
      load = 1'b0;
      step();
      check_eq("sc_q", 32'(q6), 0);
      check_eq("sc_phase", 32'(ph6), 0);
      check_eq("sc_illegal", 32'(il6), 0);
      check_eq("sc_wrap", 32'(wr6), 0);
      check_eq("nc_hold_q", 32'(qn), 32'h15);
      check_eq("nc_hold_flag", 32'(iln), 1);
      en = 1'b1; dir = 1'b0;
      step();
      check_eq("sc_step_q", 32'(q6), 32'h01);
      check_eq("nc_step_q", 32'(qn), 32'h2B);
      check_eq("nc_step_phase", 32'(phn), 0);
      check_eq("nc_step_flag", 32'(iln), 1);
      load = 1'b1; load_val = 6'b000011; en = 1'b0;
      step();
      check_eq("nc_reload_q", 32'(qn), 32'h03);
      check_eq("nc_reload_phase", 32'(phn), 2);
      check_eq("nc_reload_flag", 32'(iln), 0);

      // 6: reset overrides load and en at 111110
      load = 1'b0; en = 1'b1; dir = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check_eq("pre_rst_q", 32'(q6), 32'h3E);
      check_eq("pre_rst_phase", 32'(ph6), 7);
      rst = 1'b1; load = 1'b1; load_val = 6'b111111; load_val2 = 2'b11;
      step();
      check_eq("mid_rst_q", 32'(q6), 0);
      check_eq("mid_rst_phase", 32'(ph6), 0);
      check_eq("mid_rst_wrap", 32'(wr6), 0);
      check_eq("mid_rst_w2_q", 32'(q2), 0);
      check_eq("mid_rst_w2_illegal", 32'(il2), 0);
      rst = 1'b0; load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq($sformatf("w2_post_q[%0d]", i), 32'(q2), 32'(w2_tab[i]));
         check_eq($sformatf("w2_post_phase[%0d]", i), 32'(ph2), 32'((i + 1) % 4));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
